// File: rtl/gpio_mul_pkg.sv
// gpio_mul_pkg: shared types, default widths and the nibble popcount helper for the GPIO multiply scheduler
package gpio_mul_pkg;
   typedef enum logic [1:0] {IDLE, MULT, POPC, DONE} state_t;
   localparam int OPW_DEF   = 24;
   localparam int RESW_DEF  = 32;
   localparam int POPC_STEP = 4;
   function automatic logic [2:0] popcount4(input logic [3:0] n);
      return 3'(n[0]) + 3'(n[1]) + 3'(n[2]) + 3'(n[3]);
   endfunction
endpackage

// File: rtl/gpio_rr_arbiter.sv
// gpio_rr_arbiter: round-robin one-hot grant over NREQ requesters
// Ports: clk, n_reset (async active-low); req_valid requests; accept strobe
// advances the pointer to the granted index; grant one-hot; grant_id its index.
module gpio_rr_arbiter #(
   parameter int NREQ = 2,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            n_reset,
   input  logic [NREQ-1:0] req_valid,
   input  logic            accept,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_id
);
   logic [IDW-1:0] last_id;
   logic [IDW-1:0] idx;
   logic           found;
   int             s;

   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) last_id <= IDW'(NREQ - 1);
      else if (accept) last_id <= grant_id;

   // Search starts just after the last winner, so the previous grantee is considered last.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      s        = 0;
      idx      = '0;
      for (int o = 1; o <= NREQ; o++) begin
         s   = int'(last_id) + o;
         s   = s >= NREQ ? s - NREQ : s;
         idx = IDW'(s);
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = idx;
         end
      end
   end
endmodule

// File: rtl/gpio_mul_scheduler.sv
// gpio_mul_scheduler: round-robin sequencer for a bit-serial multiply followed by a nibble-serial ones count
// Ports: clk, n_reset (async active-low); req_valid/req_ready/req_a1/req_a2 per-requester job port
// (operands packed OPW bits per requester); rsp_valid/rsp_ready response handshake carrying
// rsp_id, rsp_w (low RESW product bits), rsp_ones, rsp_ovf; busy; op_count completed responses.
// Build option: MUL_SCHED_EARLY_TERM_EN ends the multiply once the remaining multiplier bits are zero.
module gpio_mul_scheduler
   import gpio_mul_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int OPW  = OPW_DEF,
   parameter int RESW = RESW_DEF,
   localparam int IDW = $clog2(NREQ),
   localparam int OW  = $clog2(RESW) + 1
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*OPW-1:0] req_a1,
   input  logic [NREQ*OPW-1:0] req_a2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [RESW-1:0]   rsp_w,
   output logic [OW-1:0]     rsp_ones,
   output logic              rsp_ovf,
   output logic              busy,
   output logic [15:0]       op_count
);
   localparam int CW = $clog2(OPW);

   state_t            state, state_nx;
   logic [OPW-1:0]    a2_sh;
   logic [2*OPW-1:0]  mcand, acc;
   logic [CW-1:0]     cnt;
   logic [OW-1:0]     ones;
   logic [IDW-1:0]    id;
   logic [NREQ-1:0]   grant;
   logic [IDW-1:0]    grant_id;
   logic              accept, mult_last, popc_last;
   logic [RESW-1:0]   nib_sh;
   logic [3:0]        nib;

   gpio_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk      (clk),
      .n_reset  (n_reset),
      .req_valid(req_valid),
      .accept   (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req_ready = (state == IDLE && n_reset) ? grant : '0;
   assign accept    = |(req_valid & req_ready);
`ifdef MUL_SCHED_EARLY_TERM_EN
   // The bit being consumed now is the last set one when nothing remains above it.
   assign mult_last = ~|a2_sh[OPW-1:1];
`else
   assign mult_last = cnt == CW'(OPW - 1);
`endif
   assign popc_last = cnt == CW'(RESW / POPC_STEP - 1);
   assign nib_sh    = acc[RESW-1:0] >> (POPC_STEP * cnt);
   assign nib       = nib_sh[3:0];
   assign rsp_valid = state == DONE;
   assign busy      = state != IDLE;
   assign rsp_w     = acc[RESW-1:0];
   assign rsp_ones  = ones;
   assign rsp_id    = id;
   generate
      if (RESW < 2 * OPW) begin : g_ovf
         assign rsp_ovf = |acc[2*OPW-1:RESW];
      end else begin : g_no_ovf
         assign rsp_ovf = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = accept    ? MULT : IDLE;
         MULT:    state_nx = mult_last ? POPC : MULT;
         POPC:    state_nx = popc_last ? DONE : POPC;
         DONE:    state_nx = rsp_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   // The multiplicand is kept pre-shifted instead of tracking k explicitly.
   always_ff @(posedge clk or negedge n_reset)
      if (!n_reset) begin
         mcand    <= '0;
         a2_sh    <= '0;
         acc      <= '0;
         cnt      <= '0;
         ones     <= '0;
         id       <= '0;
         op_count <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               mcand <= {{OPW{1'b0}}, req_a1[grant_id*OPW +: OPW]};
               a2_sh <= req_a2[grant_id*OPW +: OPW];
               acc   <= '0;
               cnt   <= '0;
               ones  <= '0;
               id    <= grant_id;
            end
            MULT: begin
               if (a2_sh[0]) acc <= acc + mcand;
               mcand <= mcand << 1;
               a2_sh <= a2_sh >> 1;
               cnt   <= mult_last ? '0 : cnt + 1'b1;
            end
            POPC: begin
               ones <= ones + OW'(popcount4(nib));
               cnt  <= cnt + 1'b1;
            end
            DONE: if (rsp_ready) op_count <= op_count + 16'd1;
            default: ;
         endcase
      end
endmodule
